// File: rtl/counter_mod_n_sat_pkg.sv
// counter_mod_n_sat_pkg: shared direction and mode constants for the modulo-N counter
package counter_mod_n_sat_pkg;
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam int   MODE_SAT     = 0;
    localparam int   MODE_RECYCLE = 1;
endpackage

// File: rtl/counter_mod_n_sat_tick_prescaler.sv
// tick_prescaler: divides enabled cycles by PRESCALE into a single-cycle tick
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("tick_prescaler: PRESCALE must be at least 1");
    end

    logic [PW-1:0] phase;

    assign tick = en && (phase == PW'(PRESCALE - 1));

    // phase counts enabled cycles, wraps on tick, restarts on a load
    always_ff @(posedge clk or posedge clear) begin
        if (clear)         phase <= '0;
        else if (sync_clr) phase <= '0;
        else if (tick)     phase <= '0;
        else if (en)       phase <= phase + 1'b1;
    end
endmodule

// File: rtl/counter_mod_n_sat.sv
// counter_mod_n_sat: up/down modulo-N counter with saturate/recycle mode, prescaler, load and terminal flags
module counter_mod_n_sat
    import counter_mod_n_sat_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX      = 7,
    parameter int RECYCLE  = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             done
);
    if (WIDTH < 1 || MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
        $error("counter_mod_n_sat: MAX must lie in 1 .. 2**WIDTH-1");
    end
    if (RECYCLE != MODE_SAT && RECYCLE != MODE_RECYCLE) begin : g_bad_mode
        $error("counter_mod_n_sat: RECYCLE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic             tick;
    logic             going_up;
    logic             at_lim;
    logic             hit;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .sync_clr (load),
        .tick     (tick)
    );

    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);

    // next value on a step; hit flags a real move onto the directional terminal value
    always_comb begin
        going_up     = (up_dn == DIR_UP);
        at_lim       = going_up ? at_max : at_zero;
        stepped      = at_lim ? ((RECYCLE == MODE_RECYCLE) ? (going_up ? '0 : MAXV) : count)
                              : (going_up ? count + WIDTH'(1) : count - WIDTH'(1));
        hit          = !at_lim && (going_up ? (count == MAXV - WIDTH'(1)) : (count == WIDTH'(1)));
        load_clamped = (load_val > MAXV) ? MAXV : load_val;
    end

    // count register and done pulse: load beats step beats hold
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            done  <= 1'b0;
        end else if (tick) begin
            count <= stepped;
            done  <= hit;
        end else begin
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_mod_n_sat.sv
// tb_counter_mod_n_sat: directed checks over four counter configurations
module tb_counter_mod_n_sat;
    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [2:0] lv3 = 3'd0;
    logic [3:0] lv4 = 4'd0;
    logic [2:0] c0, c1, c2;
    logic [3:0] c3;
    logic       m0, m1, m2, m3, z0, z1, z2, z3, d0, d1, d2, d3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_mod_n_sat u0 (.clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv3), .count(c0), .at_max(m0), .at_zero(z0), .done(d0));
    counter_mod_n_sat #(.WIDTH(3), .MAX(5), .RECYCLE(1), .PRESCALE(1)) u1 (.clk(clk), .clear(clear),
        .en(en), .up_dn(up_dn), .load(load), .load_val(lv3), .count(c1), .at_max(m1), .at_zero(z1), .done(d1));
    counter_mod_n_sat #(.WIDTH(3), .MAX(7), .RECYCLE(0), .PRESCALE(4)) u2 (.clk(clk), .clear(clear),
        .en(en), .up_dn(up_dn), .load(load), .load_val(lv3), .count(c2), .at_max(m2), .at_zero(z2), .done(d2));
    counter_mod_n_sat #(.WIDTH(4), .MAX(9), .RECYCLE(0), .PRESCALE(1)) u3 (.clk(clk), .clear(clear),
        .en(en), .up_dn(up_dn), .load(load), .load_val(lv4), .count(c3), .at_max(m3), .at_zero(z3), .done(d3));

    task automatic pulse_clear;
        @(posedge clk); #1;
        en = 1'b0; load = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks += 4;
        if ({c0, c1, c2} !== 9'd0 || c3 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d %0d %0d %0d, expected all 0", c0, c1, c2, c3); end
        if ({z0, z1, z2, z3} !== 4'b1111) begin errors++; $display("FAIL reset_at_zero: got %b, expected 1111", {z0, z1, z2, z3}); end
        if ({m0, m1, m2, m3} !== 4'b0000) begin errors++; $display("FAIL reset_at_max: got %b, expected 0000", {m0, m1, m2, m3}); end
        if ({d0, d1, d2, d3} !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b, expected 0000", {d0, d1, d2, d3}); end
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_sat_up;
        int e;
        pulse_clear();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            e = (i > 7) ? 7 : i;
            checks += 3;
            if (c0 !== 3'(e)) begin errors++; $display("FAIL sat_up_count step %0d: got %0d, expected %0d", i, c0, e); end
            if (d0 !== (i == 7)) begin errors++; $display("FAIL sat_up_done step %0d: got %b, expected %b", i, d0, i == 7); end
            if (m0 !== (e == 7)) begin errors++; $display("FAIL sat_up_at_max step %0d: got %b, expected %b", i, m0, e == 7); end
        end
        en = 1'b0;
    endtask

    task automatic test_mid_clear;
        pulse_clear();
        en = 1'b1; up_dn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (c0 !== 3'd4) begin errors++; $display("FAIL mid_clear_pre: got %0d, expected 4", c0); end
        #2 clear = 1'b1;
        #1;
        checks += 2;
        if (c0 !== 3'd0) begin errors++; $display("FAIL mid_clear_async: got %0d, expected 0", c0); end
        if (z0 !== 1'b1 || d0 !== 1'b0) begin errors++; $display("FAIL mid_clear_flags: got at_zero=%b done=%b, expected 1 0", z0, d0); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (c0 !== 3'd0) begin errors++; $display("FAIL mid_clear_hold: got %0d, expected 0", c0); end
        clear = 1'b0;
        #1;
        checks++;
        if (c0 !== 3'd0) begin errors++; $display("FAIL mid_clear_release: got %0d, expected 0", c0); end
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (c0 !== 3'(i)) begin errors++; $display("FAIL mid_clear_restart step %0d: got %0d, expected %0d", i, c0, i); end
        end
        en = 1'b0;
    endtask

    task automatic test_direction_change;
        int e;
        pulse_clear();
        en = 1'b1; up_dn = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (c0 !== 3'd7 || d0 !== 1'b0) begin errors++; $display("FAIL dir_saturated: got count=%0d done=%b, expected 7 0", c0, d0); end
        up_dn = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            e = (i >= 7) ? 0 : 7 - i;
            checks += 3;
            if (c0 !== 3'(e)) begin errors++; $display("FAIL dir_down_count step %0d: got %0d, expected %0d", i, c0, e); end
            if (d0 !== (i == 7)) begin errors++; $display("FAIL dir_down_done step %0d: got %b, expected %b", i, d0, i == 7); end
            if (z0 !== (e == 0)) begin errors++; $display("FAIL dir_down_at_zero step %0d: got %b, expected %b", i, z0, e == 0); end
        end
        en = 1'b0; up_dn = 1'b1;
    endtask

    task automatic test_recycle_down;
        int exp_seq[8] = '{5, 4, 3, 2, 1, 0, 5, 4};
        pulse_clear();
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks += 3;
            if (c1 !== 3'(exp_seq[i])) begin errors++; $display("FAIL recycle_count step %0d: got %0d, expected %0d", i, c1, exp_seq[i]); end
            if (d1 !== (i == 5)) begin errors++; $display("FAIL recycle_done step %0d: got %b, expected %b", i, d1, i == 5); end
            if (m1 !== (exp_seq[i] == 5)) begin errors++; $display("FAIL recycle_at_max step %0d: got %b, expected %b", i, m1, exp_seq[i] == 5); end
        end
        en = 1'b0; up_dn = 1'b1;
    endtask

    task automatic test_prescaler;
        pulse_clear();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (c2 !== 3'(i / 4)) begin errors++; $display("FAIL prescale_run cycle %0d: got %0d, expected %0d", i, c2, i / 4); end
        end
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (c2 !== 3'd2) begin errors++; $display("FAIL prescale_hold cycle %0d: got %0d, expected 2", i, c2); end
        end
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (c2 !== ((i == 4) ? 3'd3 : 3'd2)) begin errors++; $display("FAIL prescale_resume cycle %0d: got %0d, expected %0d", i, c2, (i == 4) ? 3 : 2); end
        end
        en = 1'b0;
    endtask

    task automatic test_load;
        pulse_clear();
        load = 1'b1; lv4 = 4'd13;
        @(posedge clk); #1;
        checks += 2;
        if (c3 !== 4'd9 || m3 !== 1'b1) begin errors++; $display("FAIL load_clamp: got count=%0d at_max=%b, expected 9 1", c3, m3); end
        if (d3 !== 1'b0) begin errors++; $display("FAIL load_no_done: got %b, expected 0", d3); end
        en = 1'b1; up_dn = 1'b1; lv4 = 4'd2;
        @(posedge clk); #1;
        checks++;
        if (c3 !== 4'd2) begin errors++; $display("FAIL load_beats_tick: got %0d, expected 2", c3); end
        load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (c3 !== 4'd3) begin errors++; $display("FAIL load_then_step: got %0d, expected 3", c3); end
        load = 1'b1; lv4 = 4'd8;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (c3 !== 4'd9 || d3 !== 1'b1) begin errors++; $display("FAIL load_step_to_max: got count=%0d done=%b, expected 9 1", c3, d3); end
        @(posedge clk); #1;
        checks++;
        if (c3 !== 4'd9 || d3 !== 1'b0) begin errors++; $display("FAIL load_sat_hold: got count=%0d done=%b, expected 9 0", c3, d3); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sat_up();
        test_mid_clear();
        test_direction_change();
        test_recycle_down();
        test_prescaler();
        test_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
